// File: rtl/sd_converter.sv
// Stochastic-to-digital converter: counts ones over a 2^PRECISION-sample window
// and delivers the saturated count through a one-entry valid/ready output register.
module sd_converter #(
  parameter int PRECISION = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 in,
  output logic [PRECISION-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 overrun,
  output logic [0:0]           o_dbg_state
);

  // Output handshake: a result transfers on any rising edge where out_valid=1 and
  // out_ready=1; while out_valid=1 and out_ready=0, out and out_valid are frozen.

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  localparam logic [PRECISION:0] C_LAST = {1'b0, {PRECISION{1'b1}}};
  localparam logic [PRECISION:0] C_ONE  = {{PRECISION{1'b0}}, 1'b1};

  logic [0:0]           r_state;
  logic [PRECISION:0]   r_ones;
  logic [PRECISION:0]   r_cnt;
  logic [PRECISION-1:0] r_out;
  logic                 r_out_valid;
  logic                 r_overrun;

  logic                 w_done;
  logic                 w_start_ok;
  logic [PRECISION:0]   w_ones_next;
  logic [PRECISION-1:0] w_result;

  always_comb begin
    w_start_ok  = (r_state == S_IDLE) && start;
    w_done      = (r_state == S_ACCUM) && in_valid && (r_cnt == C_LAST);
    w_ones_next = r_ones + {{PRECISION{1'b0}}, in};
    // A window of all ones counts to 2^PRECISION, which does not fit the result.
    w_result    = w_ones_next[PRECISION] ? {PRECISION{1'b1}} : w_ones_next[PRECISION-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ones  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ACCUM;
            r_ones  <= '0;
            r_cnt   <= '0;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            r_cnt  <= r_cnt + C_ONE;
            r_ones <= w_ones_next;
            if (r_cnt == C_LAST) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_overrun <= 1'b0;
      end
      // A result may load into a full register only if the old one leaves this edge.
      if (w_done) begin
        if (!r_out_valid || out_ready) begin
          r_out       <= w_result;
          r_out_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out         = r_out;
  assign out_valid   = r_out_valid;
  assign busy        = (r_state == S_ACCUM);
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sd_converter.sv
// Randomized bench for sd_converter: stimulus is generated per window and the
// expected result is the saturated count of ones over the valid samples.
module tb_sd_converter;

  localparam int P   = 8;
  localparam int WIN = 1 << P;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_bit = 1'b0;
  logic [P-1:0] out_val;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         overrun;
  logic [0:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [P-1:0] exp_q[$];

  sd_converter #(.PRECISION(P)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in(in_bit),
    .out(out_val), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
  endtask

  // bit_mode: 0 ones, 1 zeros, 2 alternate, 3 random p/256, 4 lfsr<p, 5 first p ones
  // vld_mode: 0 always valid, 1 toggle 1,0, 2 random ~70%
  task automatic run_window(input int bit_mode, input int vld_mode, input int p,
                            input bit ready_last, input bit mid_start, output int result);
    int n, k, ones;
    bit v, b;
    logic [7:0] lfsr;
    logic ov0;
    logic [P-1:0] out0;
    ov0 = out_valid; out0 = out_val;
    lfsr = 8'h01; n = 0; k = 0; ones = 0;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", busy, 1);
    check_val("overrun_cleared_by_start", overrun, 0);
    while (n < WIN && k < 4000) begin
      case (vld_mode)
        0: v = 1'b1;
        1: v = (k % 2 == 0);
        default: v = ($urandom_range(0, 9) < 7);
      endcase
      case (bit_mode)
        0: b = 1'b1;
        1: b = 1'b0;
        2: b = (n % 2 == 0);
        3: b = ($urandom_range(0, 255) < p);
        4: b = (int'(lfsr) < p);
        default: b = (n < p);
      endcase
      if (!v) b = 1'($urandom_range(0, 1));
      if (v && n == WIN - 1) begin
        check_val("no_early_valid", out_valid, ov0);
        check_val("no_early_out", out_val, out0);
        if (ready_last) out_ready = 1'b1;
      end
      start = mid_start && (k == 50);
      in_valid = v; in_bit = b;
      if (v) begin
        n++;
        ones += int'(b);
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
      k++;
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    if (n < WIN) check_val("window_timeout", n, WIN);
    result = (ones > WIN - 1) ? WIN - 1 : ones;
  endtask

  task automatic check_loaded(input string tag, input int result);
    check_val({tag, "_valid"}, out_valid, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_overrun"}, overrun, 0);
    exp_q.push_back(P'(result));
  endtask

  // scoreboard drain: compare the held value, accept it, confirm valid drops
  task automatic drain();
    logic [P-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("out_value", out_val, e);
      check_val("out_valid_before_accept", out_valid, 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_val("out_valid_after_accept", out_valid, 0);
    end
  endtask

  initial begin
    int r, d;
    do_reset();
    check_val("reset_out", out_val, 0);
    check_val("reset_out_valid", out_valid, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_overrun", overrun, 0);

    run_window(0, 0, 0, 1'b0, 1'b0, r);
    check_val("all_ones_saturates", r, 255);
    check_loaded("all_ones", r);
    drain();

    run_window(1, 0, 0, 1'b0, 1'b0, r);
    check_loaded("all_zeros", r);
    drain();

    run_window(2, 0, 0, 1'b0, 1'b0, r);
    check_val("alternate_model", r, 128);
    check_loaded("alternate", r);
    drain();

    run_window(4, 0, 8'h40, 1'b0, 1'b0, r);
    d = int'(out_val) - 64;
    check_val("lfsr_within_16", (d >= -16 && d <= 16), 1);
    check_loaded("lfsr", r);
    drain();

    run_window(0, 1, 0, 1'b0, 1'b1, r);
    check_loaded("toggle_valid_mid_start", r);
    drain();

    for (int i = 0; i < 6; i++) begin
      run_window(3, 2, $urandom_range(0, 256), 1'b0, (i == 2), r);
      check_loaded("random", r);
      drain();
    end

    // overrun: hold out_ready low across two windows
    run_window(5, 0, 10, 1'b0, 1'b0, r);
    check_val("ovr_first_out", out_val, 10);
    check_val("ovr_first_valid", out_valid, 1);
    check_val("ovr_first_overrun", overrun, 0);
    run_window(5, 2, 20, 1'b0, 1'b0, r);
    check_val("ovr_second_out_kept", out_val, 10);
    check_val("ovr_second_valid", out_valid, 1);
    check_val("ovr_second_overrun", overrun, 1);
    check_val("ovr_second_busy", busy, 0);
    run_window(5, 0, 30, 1'b1, 1'b0, r);
    check_val("same_cycle_out", out_val, 30);
    check_val("same_cycle_valid", out_valid, 1);
    check_val("same_cycle_overrun", overrun, 0);

    // asynchronous reset mid-window, with a result still held
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      if (i < 99) @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("async_rst_out", out_val, 0);
    check_val("async_rst_valid", out_valid, 0);
    check_val("async_rst_busy", busy, 0);
    check_val("async_rst_overrun", overrun, 0);
    in_valid = 1'b0; in_bit = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("post_rst_valid", out_valid, 0);
    run_window(3, 2, $urandom_range(0, 256), 1'b0, 1'b0, r);
    check_loaded("post_rst", r);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_converter.md
# sd_converter

Stochastic-to-digital converter: the consumer stage downstream of the stochastic number generator (or of any stochastic arithmetic element fed by it). It counts the ones in a window of 2^PRECISION valid stochastic bits and delivers the resulting PRECISION-bit binary value through a one-entry valid/ready output register. It closes the stochastic datapath back into the binary domain for checking and readout.

## Interface
- PRECISION, 8, binary result width; window length is 2^PRECISION valid samples
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin one conversion window; honoured only in IDLE
- in_valid  in  1  in carries a valid stochastic bit this cycle
- in  in  1  stochastic bit stream
- out  out  PRECISION  converted value, held stable while out_valid=1
- out_valid  out  1  out holds an unconsumed result
- out_ready  in  1  consumer accepts out this cycle
- busy  out  1  conversion window in progress (state ACCUM)
- overrun  out  1  sticky: a completed result was dropped because the output register was full

## Operation
- Reset (rst=0, async): state=IDLE, ones count=0, sample count=0, out=0, out_valid=0, busy=0, overrun=0.
- States: IDLE, ACCUM.
- IDLE: start=1 -> ACCUM; clear ones and sample counters; clear overrun. in is not sampled in the start cycle.
- ACCUM: each cycle with in_valid=1, sample count +1 and ones count +in. in_valid=0 cycles are ignored (no count, no timeout). start ignored.
- Ones counter is PRECISION+1 bits (range 0..2^PRECISION); sample counter is PRECISION+1 bits.
- Window completes on the cycle the 2^PRECISION-th valid sample is taken. Result = ones count including that sample, saturated: 2^PRECISION maps to 2^PRECISION-1; otherwise unchanged.
- On completion: state -> IDLE. If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle, load result into out and out_valid=1 (no overrun). Otherwise keep old out, discard result, set overrun=1.
- Output handshake: transfer when out_valid=1 and out_ready=1; out_valid clears next edge unless a new result loads the same edge. out and out_valid never change while out_valid=1 and out_ready=0, except by reset.
- overrun stays set until the next accepted start or reset.
- out_ready is don't-care while out_valid=0.
- Reset asserted mid-window: conversion abandoned, all outputs return to reset values immediately; no partial result emitted.

## Timing
- All outputs registered; no combinational path from any input to any output.
- start sampled at edge E0 -> busy=1 after E0.
- With in_valid held 1, samples taken at edges E1..E(2^PRECISION); out_valid=1 and busy=0 after E(2^PRECISION). Start-to-result latency = 2^PRECISION+1 cycles.
- in_valid gaps extend latency one cycle per invalid cycle.
- Earliest next start: the cycle after busy falls (back-to-back windows with one dead start cycle).
- Throughput: one result per 2^PRECISION+1 cycles minimum.

## Test plan
- PRECISION=8, start, in=1 with in_valid=1 for 256 cycles -> out_valid after 257th edge from start, out=255 (saturated), busy=0, overrun=0.
- in=0 for 256 valid cycles -> out=0; then in alternating 1,0 -> out=128; LFSR-driven sng stream for input 0x40 -> out within ±16 of 64.
- in_valid toggled 1,0,1,0 with in=1 -> no counting on invalid cycles, out_valid only after 512 cycles, out=255; start asserted mid-window -> ignored, result unchanged.
- out_ready=0, run two windows (results 10 then 20) -> out stays 10, overrun=1 after second window; next start clears overrun; out_ready=1 with completion in same cycle -> out=new value, out_valid stays 1, overrun=0.
- rst driven low asynchronously at sample 100 of a window (mid-cycle) -> out_valid, busy, overrun, out go 0 immediately; after release, fresh start produces a correct full-window result.
